// File: rtl/vend_input_conditioner.sv
// Input conditioner for the vending FSM: synchronises, debounces and
// edge-detects the raw switches and sensor button, then presents one event at
// a time over a valid/ready handshake with a sticky overrun flag.
module vend_input_conditioner #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SW,
  input  logic       BTN_sensor,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ready,
  output logic [3:0] sw_stable,
  output logic       sensor_stable,
  output logic       ovr_flag,
  input  logic       ovr_clr
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam int NCH   = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    EVT_NONE   = 3'd0,
    EVT_COIN1  = 3'd1,
    EVT_COIN2  = 3'd2,
    EVT_CANDY  = 3'd3,
    EVT_SODA   = 3'd4,
    EVT_SENSOR = 3'd5
  } evt_code_e;

  // Channel order: [1:0] coin, [2] candy, [3] soda, [4] sensor
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] db_cnt [NCH];

  logic      pend_coin, pend_candy, pend_soda, pend_sensor;
  logic      pend_coin_val;        // 0 = coin1, 1 = coin2
  evt_code_e evt_code_q;

  logic coin_rise, coin_rise_val, coin_bad;
  logic candy_rise, soda_rise, sensor_rise;
  logic accept;
  logic pres_coin, pres_candy, pres_soda, pres_sensor;
  logic busy_coin, busy_candy, busy_soda, busy_sensor;
  logic new_coin, new_candy, new_soda, new_sensor;
  logic ovr_set;
  logic load;
  logic take_coin, take_candy, take_soda, take_sensor;
  evt_code_e load_code;

  assign raw           = {BTN_sensor, SW};
  assign sw_stable     = stable[3:0];
  assign sensor_stable = stable[4];
  assign evt_code      = evt_code_q;

  // Two-flop synchroniser on every raw input
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: level flips only after DB_CYCLES differing cycles
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stable   <= '0;
      stable_d <= '0;
      for (int unsigned i = 0; i < NCH; i++) db_cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Event detection on debounced levels
  always_comb begin
    coin_rise     = 1'b0;
    coin_rise_val = 1'b0;
    coin_bad      = 1'b0;
    if (stable_d[1:0] == 2'b00) begin
      case (stable[1:0])
        2'b01:   coin_rise = 1'b1;
        2'b10: begin
          coin_rise     = 1'b1;
          coin_rise_val = 1'b1;
        end
        2'b11:   coin_bad = 1'b1;
        default: ;
      endcase
    end
    candy_rise  = stable[2] & ~stable_d[2];
    soda_rise   = stable[3] & ~stable_d[3];
    sensor_rise = stable[4] & ~stable_d[4];
  end

  // Overrun qualification: a source is busy while pending or presented and not
  // being accepted this cycle, so accept + new event on one source re-arms it
  always_comb begin
    accept      = evt_valid & evt_ready;
    pres_coin   = evt_valid & ((evt_code_q == EVT_COIN1) | (evt_code_q == EVT_COIN2));
    pres_candy  = evt_valid & (evt_code_q == EVT_CANDY);
    pres_soda   = evt_valid & (evt_code_q == EVT_SODA);
    pres_sensor = evt_valid & (evt_code_q == EVT_SENSOR);
    busy_coin   = pend_coin   | (pres_coin   & ~accept);
    busy_candy  = pend_candy  | (pres_candy  & ~accept);
    busy_soda   = pend_soda   | (pres_soda   & ~accept);
    busy_sensor = pend_sensor | (pres_sensor & ~accept);
    new_coin    = coin_rise   & ~busy_coin;
    new_candy   = candy_rise  & ~busy_candy;
    new_soda    = soda_rise   & ~busy_soda;
    new_sensor  = sensor_rise & ~busy_sensor;
    ovr_set     = coin_bad
                | (coin_rise   & busy_coin)
                | (candy_rise  & busy_candy)
                | (soda_rise   & busy_soda)
                | (sensor_rise & busy_sensor);
  end

  // Fixed-priority arbitration: sensor > coin > candy > soda
  always_comb begin
    load        = ~evt_valid & (pend_sensor | pend_coin | pend_candy | pend_soda);
    take_sensor = 1'b0;
    take_coin   = 1'b0;
    take_candy  = 1'b0;
    take_soda   = 1'b0;
    load_code   = EVT_NONE;
    if (pend_sensor) begin
      take_sensor = load;
      load_code   = EVT_SENSOR;
    end else if (pend_coin) begin
      take_coin   = load;
      load_code   = pend_coin_val ? EVT_COIN2 : EVT_COIN1;
    end else if (pend_candy) begin
      take_candy  = load;
      load_code   = EVT_CANDY;
    end else if (pend_soda) begin
      take_soda   = load;
      load_code   = EVT_SODA;
    end
  end

  // Pending bits: a pending event moves into the output register when loaded
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_coin     <= 1'b0;
      pend_coin_val <= 1'b0;
      pend_candy    <= 1'b0;
      pend_soda     <= 1'b0;
      pend_sensor   <= 1'b0;
    end else begin
      if (new_coin) begin
        pend_coin     <= 1'b1;
        pend_coin_val <= coin_rise_val;
      end else if (take_coin) begin
        pend_coin     <= 1'b0;
      end
      if (new_candy)       pend_candy  <= 1'b1;
      else if (take_candy) pend_candy  <= 1'b0;
      if (new_soda)        pend_soda   <= 1'b1;
      else if (take_soda)  pend_soda   <= 1'b0;
      if (new_sensor)       pend_sensor <= 1'b1;
      else if (take_sensor) pend_sensor <= 1'b0;
    end
  end

  // Output register: holds until accepted, then idles one cycle before reload
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      evt_valid  <= 1'b0;
      evt_code_q <= EVT_NONE;
    end else if (accept) begin
      evt_valid  <= 1'b0;
      evt_code_q <= EVT_NONE;
    end else if (load) begin
      evt_valid  <= 1'b1;
      evt_code_q <= load_code;
    end
  end

  // Sticky overrun flag; a set in the same cycle as a clear wins
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         ovr_flag <= 1'b0;
    else if (ovr_set) ovr_flag <= 1'b1;
    else if (ovr_clr) ovr_flag <= 1'b0;
  end

endmodule

// File: tb/tb_vend_input_conditioner.sv
// Directed bench for vend_input_conditioner with DB_CYCLES=4 (raw edge to
// evt_valid = 8 cycles). Accepted events are checked against a queue of
// expected codes pushed when stimulus is driven.
module tb_vend_input_conditioner;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] SW;
  logic       BTN_sensor;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_ready;
  logic [3:0] sw_stable;
  logic       sensor_stable;
  logic       ovr_flag;
  logic       ovr_clr;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q [$];

  vend_input_conditioner #(.DB_CYCLES(4)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SW           (SW),
    .BTN_sensor   (BTN_sensor),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ready    (evt_ready),
    .sw_stable    (sw_stable),
    .sensor_stable(sensor_stable),
    .ovr_flag     (ovr_flag),
    .ovr_clr      (ovr_clr)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every accepted event must match the oldest expected code
  always @(negedge CLK) begin
    if (RST === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_event observed=%0d expected=none", evt_code);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        total++;
        assert (evt_code === e) else begin
          bad++;
          $error("FAIL event_code observed=%0d expected=%0d", evt_code, e);
        end
      end
    end
  end

  initial begin
    RST = 1'b0; SW = 4'b0000; BTN_sensor = 1'b0; evt_ready = 1'b1; ovr_clr = 1'b0;
    step(3);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_code",  32'(evt_code),  32'd0);
    check("rst_ovr",   32'(ovr_flag),  32'd0);
    check("rst_sw_stable", 32'(sw_stable), 32'd0);
    RST = 1'b1;
    step(3);

    // Candy rise: exact 8-cycle latency, single-cycle valid with ready=1
    SW[2] = 1'b1; exp_q.push_back(3'd3);
    step(6);
    check("candy_stable", 32'(sw_stable[2]), 32'd1);
    step(1);
    check("candy_not_yet", 32'(evt_valid), 32'd0);
    step(1);
    check("candy_valid", 32'(evt_valid), 32'd1);
    check("candy_code",  32'(evt_code),  32'd3);
    step(1);
    check("candy_one_cycle", 32'(evt_valid), 32'd0);
    SW[2] = 1'b0;
    step(12);

    // Soda glitch of 3 cycles is filtered
    SW[3] = 1'b1; step(3); SW[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("soda_glitch_stable", 32'(sw_stable[3]), 32'd0);
      step(1);
    end
    check("soda_glitch_no_evt", 32'(evt_valid), 32'd0);
    // Soda held 4 cycles passes
    SW[3] = 1'b1; exp_q.push_back(3'd4);
    step(4); SW[3] = 1'b0;
    step(4);
    check("soda_valid", 32'(evt_valid), 32'd1);
    check("soda_code",  32'(evt_code),  32'd4);
    step(14);

    // Coin2 held off by ready=0 for 20 cycles
    evt_ready = 1'b0;
    SW[1:0] = 2'b10; exp_q.push_back(3'd2);
    step(8);
    for (int k = 0; k < 20; k++) begin
      check("coin2_hold_valid", 32'(evt_valid), 32'd1);
      check("coin2_hold_code",  32'(evt_code),  32'd2);
      step(1);
    end
    evt_ready = 1'b1;
    step(1);
    check("coin2_drop_valid", 32'(evt_valid), 32'd0);
    check("coin2_drop_code",  32'(evt_code),  32'd0);
    step(3);
    check("coin2_idle", 32'(evt_valid), 32'd0);
    SW[1:0] = 2'b00;
    step(12);

    // Sensor and candy together: sensor first, one idle cycle, then candy
    SW[2] = 1'b1; BTN_sensor = 1'b1;
    exp_q.push_back(3'd5); exp_q.push_back(3'd3);
    step(8);
    check("arb_first_valid", 32'(evt_valid), 32'd1);
    check("arb_first_code",  32'(evt_code),  32'd5);
    step(1);
    check("arb_gap", 32'(evt_valid), 32'd0);
    step(1);
    check("arb_second_valid", 32'(evt_valid), 32'd1);
    check("arb_second_code",  32'(evt_code),  32'd3);
    step(1);
    check("arb_done", 32'(evt_valid), 32'd0);
    SW[2] = 1'b0; BTN_sensor = 1'b0;
    step(12);

    // Candy overrun while first candy is still outstanding
    evt_ready = 1'b0;
    SW[2] = 1'b1; exp_q.push_back(3'd3);
    step(8);
    check("ovr_first_code", 32'(evt_code), 32'd3);
    SW[2] = 1'b0; step(6);
    SW[2] = 1'b1; step(10);
    check("ovr_set",        32'(ovr_flag),  32'd1);
    check("ovr_held_valid", 32'(evt_valid), 32'd1);
    check("ovr_held_code",  32'(evt_code),  32'd3);
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    check("ovr_cleared", 32'(ovr_flag), 32'd0);
    evt_ready = 1'b1;
    step(1);
    check("ovr_accepted", 32'(evt_valid), 32'd0);
    step(10);
    check("ovr_single_evt", 32'(evt_valid), 32'd0);
    SW[2] = 1'b0;
    step(12);

    // Coin 00 -> 11: no event, overrun flagged
    SW[1:0] = 2'b11;
    step(10);
    check("coin11_ovr", 32'(ovr_flag),  32'd1);
    check("coin11_noevt", 32'(evt_valid), 32'd0);
    SW[1:0] = 2'b00;
    step(12);

    // Asynchronous reset while an event is presented
    evt_ready = 1'b0;
    SW[3] = 1'b1;
    step(8);
    check("pre_rst_valid", 32'(evt_valid), 32'd1);
    #2 RST = 1'b0;
    #1;
    check("arst_valid", 32'(evt_valid), 32'd0);
    check("arst_code",  32'(evt_code),  32'd0);
    check("arst_ovr",   32'(ovr_flag),  32'd0);
    SW[3] = 1'b0; evt_ready = 1'b1;
    step(3);
    RST = 1'b1;
    step(12);
    check("post_rst_noevt", 32'(evt_valid), 32'd0);
    SW[3] = 1'b1; exp_q.push_back(3'd4);
    step(8);
    check("post_rst_valid", 32'(evt_valid), 32'd1);
    check("post_rst_code",  32'(evt_code),  32'd4);
    step(1);
    check("post_rst_done", 32'(evt_valid), 32'd0);
    SW[3] = 1'b0;
    step(12);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
